// File: rtl/ram_access_unit.sv
// Load/store front end for a word-wide RAM with byte-lane write mask.
// Optional misaligned-access rejection: define RAM_ACCESS_MISALIGN_ERR_EN.
module ram_access_unit #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic                 ram_wr,
  output logic [3:0]           ram_wr_mask,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [31:0]          ram_data_in,
  input  logic [31:0]          ram_data_out
);

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_BITS-1:0] cap_addr;
  logic [1:0]           cap_size;
  logic [1:0]           cap_off;
  logic                 cap_signed;

  logic [1:0]  eff_size;
  logic [1:0]  off;
  logic        mis_err;
  logic        accept;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic        unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_BITS+2];

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_ready && req_valid;

  // Size/offset decode; offsets are always aligned down to the access size.
  always_comb begin
    eff_size = (req_size == 2'b11) ? 2'b10 : req_size;
    off      = req_addr[1:0];
    mis_err  = 1'b0;
    unique case (1'b1)
      eff_size == 2'b01: off = {req_addr[1], 1'b0};
      eff_size == 2'b10: off = 2'b00;
      default:           off = req_addr[1:0];
    endcase
`ifdef RAM_ACCESS_MISALIGN_ERR_EN
    mis_err = (req_size == 2'b11) ||
              (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
    mis_err = 1'b0;
`endif
  end

  // Store lane replication and byte mask.
  always_comb begin
    ram_wr_mask = 4'b1111;
    ram_data_in = req_wdata;
    unique case (1'b1)
      eff_size == 2'b00: begin
        ram_wr_mask = 4'b0001 << off;
        ram_data_in = {4{req_wdata[7:0]}};
      end
      eff_size == 2'b01: begin
        ram_wr_mask = 4'b0011 << off;
        ram_data_in = {2{req_wdata[15:0]}};
      end
      default: begin
        ram_wr_mask = 4'b1111;
        ram_data_in = req_wdata;
      end
    endcase
  end

  // RAM port: address follows the request while idle, write only on accept.
  always_comb begin
    ram_addr = cap_addr;
    if (state == IDLE) begin
      ram_addr = req_addr[ADDR_BITS+1:2];
    end
    ram_wr = accept && req_wr && !mis_err && !rst;
  end

  // Lane select and extension of the registered RAM read.
  always_comb begin
    shifted  = ram_data_out >> {cap_off, 3'b000};
    load_val = shifted;
    unique case (1'b1)
      cap_size == 2'b00:
        load_val = {{24{cap_signed & shifted[7]}}, shifted[7:0]};
      cap_size == 2'b01:
        load_val = {{16{cap_signed & shifted[15]}}, shifted[15:0]};
      default:
        load_val = shifted;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = (req_wr || mis_err) ? RESP : READ_WAIT;
        end
      end
      READ_WAIT: state_nx = RESP;
      RESP: begin
        if (resp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Capture the accepted request for the read completion cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_addr   <= '0;
      cap_size   <= 2'b00;
      cap_off    <= 2'b00;
      cap_signed <= 1'b0;
    end else if (accept) begin
      cap_addr   <= req_addr[ADDR_BITS+1:2];
      cap_size   <= eff_size;
      cap_off    <= off;
      cap_signed <= req_signed;
    end
  end

  // Response payload: zero for stores/errors, extended data for loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      resp_rdata <= '0;
      resp_err   <= mis_err;
    end else if (state == READ_WAIT) begin
      resp_rdata <= load_val;
      resp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_access_unit.sv
// Bench for ram_access_unit: vector table, corner sequences,
// and random traffic checked against a byte-array memory model.
module tb_ram_access_unit;

  localparam int AB = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          ram_wr;
  logic [3:0]    ram_wr_mask;
  logic [AB-1:0] ram_addr;
  logic [31:0]   ram_data_in;
  logic [31:0]   ram_data_out;

  int total = 0;
  int bad = 0;

  ram_access_unit #(.ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_wr(ram_wr), .ram_wr_mask(ram_wr_mask),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Attached RAM: masked write, registered read.
  logic [31:0] ram [0:(1<<AB)-1];
  always @(posedge clk) begin
    if (ram_wr) begin
      for (int l = 0; l < 4; l++) begin
        if (ram_wr_mask[l]) ram[ram_addr][8*l +: 8] <= ram_data_in[8*l +: 8];
      end
    end
    ram_data_out <= ram[ram_addr];
  end

  // Reference memory as plain bytes.
  logic [7:0] ref_b [0:(4<<AB)-1];

  task automatic model(input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output bit err, output logic [31:0] rd);
    int nb;
    int ea;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
`ifdef RAM_ACCESS_MISALIGN_ERR_EN
    err = (sz == 2'd3) || (a % nb != 0);
`else
    err = 1'b0;
`endif
    ea = int'(a % (4 << AB));
    ea = ea - (ea % nb);
    rd = 32'd0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < nb; i++) ref_b[ea+i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = v + (32'(ref_b[ea+i]) << (8*i));
        if (sg && nb < 4 && v[8*nb-1]) v = v - (32'd1 << (8*nb));
        rd = v;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit wr; logic [1:0] sz; bit sg;
    logic [31:0] a; logic [31:0] wd; int dly;
  } req_t;

  typedef struct {
    logic acc_wr; logic [3:0] mask; logic [31:0] din;
    logic [AB-1:0] raddr; logic rdy; int lat;
    logic [31:0] rd; logic err; int stray; int hold_bad; logic after;
  } obs_t;

  typedef struct {
    bit wr; logic [1:0] sz; bit sg; logic [31:0] a; logic [31:0] wd;
    int dly; bit e_wr; logic [3:0] e_mask; logic [31:0] e_din;
    logic [AB-1:0] e_raddr; int e_lat; logic [31:0] e_rd; bit e_err;
  } vec_t;

  // One transaction; junk requests are driven while busy.
  task automatic run(input req_t r, output obs_t o);
    o = '{default: 0};
    @(negedge clk);
    req_valid = 1'b1; req_wr = r.wr; req_size = r.sz;
    req_signed = r.sg; req_addr = r.a; req_wdata = r.wd;
    #1;
    o.acc_wr = ram_wr; o.mask = ram_wr_mask; o.din = ram_data_in;
    o.raddr = ram_addr; o.rdy = req_ready;
    @(posedge clk);
    #1;
    req_wr = 1'b1; req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom_range(0, 3));
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ram_wr) o.stray++;
      if (resp_valid) begin
        o.lat = k;
        break;
      end
    end
    if (o.lat == 0) begin
      req_valid = 1'b0;
      return;
    end
    o.rd = resp_rdata; o.err = resp_err;
    for (int d = 0; d < r.dly; d++) begin
      @(negedge clk);
      if (ram_wr) o.stray++;
      if (resp_valid !== 1'b1 || resp_rdata !== o.rd ||
          resp_err !== o.err || req_ready !== 1'b0) o.hold_bad++;
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    o.after = req_ready && !resp_valid;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    vec_t tv[$];
    req_t r;
    obs_t o;
    bit m_err;
    logic [31:0] m_rd;
    int seen;
    string nm;

    for (int i = 0; i < (1 << AB); i++) ram[i] = 32'd0;
    for (int i = 0; i < (4 << AB); i++) ref_b[i] = 8'd0;

    // Reset state, with a store presented during reset.
    rst = 1'b1; resp_ready = 1'b0;
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b10;
    req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h11111111;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b0;

    tv.push_back('{1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 1, 4'hF, 32'hDEADBEEF, 10'd4, 1, 32'd0, 0});
    tv.push_back('{1, 2'd0, 0, 32'h13, 32'hFFFFFF5A, 1, 1, 4'h8, 32'h5A5A5A5A, 10'd4, 1, 32'd0, 0});
    tv.push_back('{0, 2'd0, 1, 32'h13, 32'h0, 0, 0, 4'h0, 32'h0, 10'd4, 2, 32'h0000005A, 0});
    tv.push_back('{1, 2'd2, 0, 32'h0, 32'h8001FF80, 0, 1, 4'hF, 32'h8001FF80, 10'd0, 1, 32'd0, 0});
    tv.push_back('{0, 2'd1, 1, 32'h2, 32'h0, 5, 0, 4'h0, 32'h0, 10'd0, 2, 32'hFFFF8001, 0});
    tv.push_back('{0, 2'd0, 0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 10'd0, 2, 32'h00000080, 0});
    tv.push_back('{0, 2'd0, 1, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 10'd0, 2, 32'hFFFFFF80, 0});
    tv.push_back('{1, 2'd1, 0, 32'h6, 32'hABCD1234, 0, 1, 4'hC, 32'h12341234, 10'd1, 1, 32'd0, 0});
    tv.push_back('{0, 2'd1, 0, 32'h6, 32'h0, 0, 0, 4'h0, 32'h0, 10'd1, 2, 32'h00001234, 0});
    tv.push_back('{0, 2'd2, 0, 32'h4, 32'h0, 0, 0, 4'h0, 32'h0, 10'd1, 2, 32'h12340000, 0});
    tv.push_back('{0, 2'd2, 0, 32'hFFFFF010, 32'h0, 0, 0, 4'h0, 32'h0, 10'd4, 2, 32'h5AADBEEF, 0});
`ifdef RAM_ACCESS_MISALIGN_ERR_EN
    tv.push_back('{0, 2'd2, 0, 32'h11, 32'h0, 0, 0, 4'h0, 32'h0, 10'd4, 1, 32'd0, 1});
    tv.push_back('{0, 2'd1, 0, 32'h13, 32'h0, 2, 0, 4'h0, 32'h0, 10'd4, 1, 32'd0, 1});
    tv.push_back('{1, 2'd3, 0, 32'h21, 32'hCAFEF00D, 0, 0, 4'h0, 32'h0, 10'd8, 1, 32'd0, 1});
    tv.push_back('{0, 2'd0, 1, 32'h22, 32'h0, 0, 0, 4'h0, 32'h0, 10'd8, 2, 32'h00000000, 0});
    tv.push_back('{0, 2'd1, 1, 32'h1, 32'h0, 0, 0, 4'h0, 32'h0, 10'd0, 1, 32'd0, 1});
`else
    tv.push_back('{0, 2'd2, 0, 32'h11, 32'h0, 0, 0, 4'h0, 32'h0, 10'd4, 2, 32'h5AADBEEF, 0});
    tv.push_back('{0, 2'd1, 0, 32'h13, 32'h0, 2, 0, 4'h0, 32'h0, 10'd4, 2, 32'h00005AAD, 0});
    tv.push_back('{1, 2'd3, 0, 32'h21, 32'hCAFEF00D, 0, 1, 4'hF, 32'hCAFEF00D, 10'd8, 1, 32'd0, 0});
    tv.push_back('{0, 2'd0, 1, 32'h22, 32'h0, 0, 0, 4'h0, 32'h0, 10'd8, 2, 32'hFFFFFFFE, 0});
    tv.push_back('{0, 2'd1, 1, 32'h1, 32'h0, 0, 0, 4'h0, 32'h0, 10'd0, 2, 32'hFFFFFF80, 0});
`endif

    foreach (tv[i]) begin
      r = '{tv[i].wr, tv[i].sz, tv[i].sg, tv[i].a, tv[i].wd, tv[i].dly};
      model(r.wr, r.sz, r.sg, r.a, r.wd, m_err, m_rd);
      run(r, o);
      nm = $sformatf("v%0d", i);
      chk({nm, "_ready"}, 32'(o.rdy), 32'd1);
      chk({nm, "_ram_wr"}, 32'(o.acc_wr), 32'(tv[i].e_wr));
      if (tv[i].e_wr) begin
        chk({nm, "_mask"}, 32'(o.mask), 32'(tv[i].e_mask));
        chk({nm, "_din"}, o.din, tv[i].e_din);
      end
      chk({nm, "_raddr"}, 32'(o.raddr), 32'(tv[i].e_raddr));
      chk({nm, "_latency"}, o.lat, tv[i].e_lat);
      chk({nm, "_rdata"}, o.rd, tv[i].e_rd);
      chk({nm, "_err"}, 32'(o.err), 32'(tv[i].e_err));
      chk({nm, "_stray_wr"}, o.stray, 32'd0);
      chk({nm, "_hold"}, o.hold_bad, 32'd0);
      chk({nm, "_idle_after"}, 32'(o.after), 32'd1);
    end

    // Reset while a load waits for RAM data.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_size = 2'b10; req_addr = 32'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("rw_rst_valid", 32'(resp_valid), 32'd0);
    chk("rw_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("rw_no_resp", seen, 32'd0);
    chk("rw_ready_after", 32'(req_ready), 32'd1);

    // Reset with a store response pending; the write must survive.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b10;
    req_addr = 32'h40; req_wdata = 32'h0BADF00D;
    model(1, 2'd2, 0, 32'h40, 32'h0BADF00D, m_err, m_rd);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rs_resp_valid", 32'(resp_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rs_rst_valid", 32'(resp_valid), 32'd0);
    chk("rs_rst_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    r = '{0, 2'd2, 0, 32'h40, 32'h0, 0};
    run(r, o);
    chk("rs_readback", o.rd, 32'h0BADF00D);

    // Random traffic against the byte model.
    for (int n = 0; n < 250; n++) begin
      r.wr = 1'($urandom_range(0, 1));
      r.sz = 2'($urandom_range(0, 3));
      r.sg = 1'($urandom_range(0, 1));
      r.a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 95));
      r.wd = $urandom;
      r.dly = $urandom_range(0, 2);
      model(r.wr, r.sz, r.sg, r.a, r.wd, m_err, m_rd);
      run(r, o);
      nm = $sformatf("rnd%0d", n);
      chk({nm, "_ram_wr"}, 32'(o.acc_wr), 32'(r.wr && !m_err));
      chk({nm, "_raddr"}, 32'(o.raddr), 32'(r.a[AB+1:2]));
      chk({nm, "_latency"}, o.lat, (r.wr || m_err) ? 1 : 2);
      chk({nm, "_rdata"}, o.rd, m_rd);
      chk({nm, "_err"}, 32'(o.err), 32'(m_err));
      chk({nm, "_hold"}, o.hold_bad + o.stray, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_access_unit.md
RAM_ACCESS_UNIT -- requirements
Module: ram_access_unit

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, word-address width of the attached RAM.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_wr  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port req_signed  input  1  sign-extend loads.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  response present.
REQ-012 SHALL have port resp_ready  input  1  consumer takes response.
REQ-013 SHALL have port resp_rdata  output  32  load result, extended; 0 for stores.
REQ-014 SHALL have port resp_err  output  1  access rejected (macro-dependent).
REQ-015 SHALL have ports ram_wr output 1, ram_wr_mask output 4, ram_addr output ADDR_BITS, ram_data_in output 32, ram_data_out input 32, driving a RAM with byte-lane write mask and 1-cycle registered read.

Function
REQ-016 SHALL implement states IDLE, READ_WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request when req_valid && req_ready (accept cycle N).
REQ-018 SHALL drive ram_addr = req_addr[ADDR_BITS+1:2] combinationally during IDLE; req_addr bits above ADDR_BITS+1 ignored.
REQ-019 SHALL assert ram_wr only in accept cycle of a non-error store; ram_wr = 0 in all other cycles.
REQ-020 SHALL, for stores, replicate byte (size 00) or half (size 01) across ram_data_in lanes; word passes through.
REQ-021 SHALL set ram_wr_mask: byte 0001<<off, half 0011<<off, word 1111, off = effective byte offset req_addr[1:0].
REQ-022 SHALL, on accepted store, transition IDLE -> RESP; resp_valid at N+1.
REQ-023 SHALL, on accepted load, transition IDLE -> READ_WAIT; in READ_WAIT latch ram_addr/size/signed/offset from the captured request, select lane(s) of ram_data_out, zero- or sign-extend to 32 bits into resp_rdata, then -> RESP; resp_valid at N+2.
REQ-024 SHALL hold resp_valid, resp_rdata, resp_err stable in RESP until resp_ready; RESP -> IDLE on resp_ready.
REQ-025 SHALL not accept a new request in the cycle resp_ready is sampled (one idle cycle between responses).
REQ-026 SHALL ignore req_* changes while not in IDLE.
REQ-027 SHALL return resp_rdata = 0 for store and error responses.

Reset
REQ-028 SHALL, on rst assertion at any time, immediately enter IDLE with resp_valid 0, resp_err 0, resp_rdata 0, ram_wr 0; pending response discarded.
REQ-029 SHALL not undo a RAM write issued before reset; a load in READ_WAIT during reset produces no response.

Configuration
REQ-030 SHALL honour macro RAM_ACCESS_MISALIGN_ERR_EN.
REQ-031 With RAM_ACCESS_MISALIGN_ERR_EN defined: half with addr[0]=1, word with addr[1:0]!=0, or size 11 SHALL produce no RAM access (ram_wr 0), IDLE -> RESP, resp_err 1 at N+1.
REQ-032 Without it: offset SHALL be aligned down (half uses addr[1], word uses 0), size 11 treated as word, resp_err constantly 0.

Verification
REQ-033 Store word 0xDEADBEEF @0x10 -> ram_wr 1, mask 1111, ram_addr 4 at N; resp_valid at N+1, rdata 0.
REQ-034 Store byte 0x5A @0x13 -> mask 1000, ram_data_in 0x5A5A5A5A; then signed byte load @0x13 -> rdata 0x0000005A at N+2.
REQ-035 RAM word 0x8001FF80; load signed half @0x2 -> 0xFFFF8001; unsigned byte @0x0 -> 0x00000080; signed byte @0x0 -> 0xFFFFFF80.
REQ-036 Load response with resp_ready held 0 for 5 cycles -> resp_valid/rdata stable, req_ready 0; resp_ready 1 -> IDLE next cycle.
REQ-037 Word load @0x11: macro defined -> resp_err 1 at N+1, no ram_wr; undefined -> reads word at ram_addr 4, resp_err 0.
REQ-038 rst pulsed while in READ_WAIT -> resp_valid never asserts, req_ready 1 after rst deasserts.
